// File: rtl/presence_pkg.sv
// Shared encodings and helpers for the doorway presence detector.
package presence_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ENT1  = 3'd1;
   localparam logic [2:0] ST_ENT2  = 3'd2;
   localparam logic [2:0] ST_ENT3  = 3'd3;
   localparam logic [2:0] ST_EXT1  = 3'd4;
   localparam logic [2:0] ST_EXT2  = 3'd5;
   localparam logic [2:0] ST_EXT3  = 3'd6;
   localparam logic [2:0] ST_ABORT = 3'd7;

   function automatic int unsigned ms_to_cyc(input int unsigned clk_hz, input int unsigned ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/beam_debouncer.sv
// Two-flop synchronizer followed by a restart-on-mismatch debounce counter.
module beam_debouncer
   import presence_pkg::*;
#(
   parameter int unsigned DB_CYC = 500_000
) (
   input  logic clk,
   input  logic rst_a_n,
   input  logic raw_i,
   output logic level_o
);

   localparam int unsigned DB_LAST = (DB_CYC > 0) ? DB_CYC - 1 : 0;
   localparam int unsigned CW      = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic [CW-1:0] r_cnt;

   // r_cnt holds how many consecutive mismatch cycles have already elapsed
   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_level <= 1'b0;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= raw_i;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CW'(DB_LAST)) begin
            r_level <= r_sync2;
            r_cnt   <= '0;
         end else begin
            r_cnt <= r_cnt + CW'(1);
         end
      end
   end

   assign level_o = r_level;

endmodule

// File: rtl/person_presence_detector.sv
// Beam-order decoder with saturating occupancy count driving person_in.
// Optional sequence timeout enabled by defining PRESENCE_TIMEOUT_EN.
module person_presence_detector
   import presence_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned TIMEOUT_MS  = 2000,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_a_n,
   input  logic             beam_out_i,
   input  logic             beam_in_i,
   input  logic             clr,
   output logic             person_in,
   output logic [CNT_W-1:0] occupancy,
   output logic             entry_pulse,
   output logic             exit_pulse,
   output logic             err_pulse
);

   localparam int unsigned      DB_CYC  = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
   localparam logic [CNT_W-1:0] OCC_MAX = '1;

   logic             w_o;
   logic             w_i;
   logic [2:0]       r_state;
   logic [2:0]       w_next;
   logic             w_cnt_in;
   logic             w_cnt_out;
   logic             w_err_seq;
   logic             w_sat_err;
   logic             w_timeout;
   logic             w_in_seq;
   logic [CNT_W-1:0] w_occ_nxt;
   logic [CNT_W-1:0] r_occ;
   logic             r_person;
   logic             r_entry;
   logic             r_exit;
   logic             r_err;

   beam_debouncer #(.DB_CYC(DB_CYC)) u_db_out (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .raw_i   (beam_out_i),
      .level_o (w_o)
   );

   beam_debouncer #(.DB_CYC(DB_CYC)) u_db_in (
      .clk     (clk),
      .rst_a_n (rst_a_n),
      .raw_i   (beam_in_i),
      .level_o (w_i)
   );

   assign w_in_seq = (r_state != ST_IDLE) && (r_state != ST_ABORT);

`ifdef PRESENCE_TIMEOUT_EN
   localparam int unsigned TO_CYC  = ms_to_cyc(CLK_HZ, TIMEOUT_MS);
   localparam int unsigned TO_LAST = (TO_CYC > 0) ? TO_CYC - 1 : 0;
   localparam int unsigned TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_to_cnt <= '0;
      end else if (w_next != r_state) begin
         r_to_cnt <= '0;
      end else if (r_to_cnt != TO_W'(TO_LAST)) begin
         r_to_cnt <= r_to_cnt + TO_W'(1);
      end
   end

   assign w_timeout = w_in_seq && (r_to_cnt == TO_W'(TO_LAST));
`else
   logic w_unused_timeout_ms;
   assign w_unused_timeout_ms = ^TIMEOUT_MS;
   assign w_timeout           = 1'b0;
`endif

   always_comb begin
      w_next    = r_state;
      w_cnt_in  = 1'b0;
      w_cnt_out = 1'b0;
      w_err_seq = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_o && w_i) begin
               w_next    = ST_ABORT;
               w_err_seq = 1'b1;
            end else if (w_o) begin
               w_next = ST_ENT1;
            end else if (w_i) begin
               w_next = ST_EXT1;
            end
         end
         ST_ENT1: if (w_i) w_next = ST_ENT2; else if (!w_o) w_next = ST_IDLE;
         ST_ENT2: begin
            if (!w_o && !w_i)  w_next = ST_IDLE;
            else if (!w_o)     w_next = ST_ENT3;
            else if (!w_i)     w_next = ST_ENT1;
         end
         ST_ENT3: begin
            if (!w_i) begin
               w_next   = ST_IDLE;
               w_cnt_in = 1'b1;
            end else if (w_o) begin
               w_next = ST_ENT2;
            end
         end
         ST_EXT1: if (w_o) w_next = ST_EXT2; else if (!w_i) w_next = ST_IDLE;
         ST_EXT2: begin
            if (!w_o && !w_i)  w_next = ST_IDLE;
            else if (!w_i)     w_next = ST_EXT3;
            else if (!w_o)     w_next = ST_EXT1;
         end
         ST_EXT3: begin
            if (!w_o) begin
               w_next    = ST_IDLE;
               w_cnt_out = 1'b1;
            end else if (w_i) begin
               w_next = ST_EXT2;
            end
         end
         ST_ABORT: if (!w_o && !w_i) w_next = ST_IDLE;
         default:  w_next = ST_IDLE;
      endcase
      // A real beam transition in the same cycle takes precedence over expiry
      if (w_timeout && (w_next == r_state)) begin
         w_next    = ST_ABORT;
         w_err_seq = 1'b1;
      end
   end

   always_comb begin
      w_occ_nxt = r_occ;
      w_sat_err = 1'b0;
      if (clr) begin
         w_occ_nxt = '0;
      end else if (w_cnt_in) begin
         if (r_occ == OCC_MAX) w_sat_err = 1'b1;
         else                  w_occ_nxt = r_occ + CNT_W'(1);
      end else if (w_cnt_out) begin
         if (r_occ == '0) w_sat_err = 1'b1;
         else             w_occ_nxt = r_occ - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         r_state  <= ST_IDLE;
         r_occ    <= '0;
         r_person <= 1'b0;
         r_entry  <= 1'b0;
         r_exit   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_next;
         r_occ    <= w_occ_nxt;
         r_person <= (w_occ_nxt != '0);
         r_entry  <= w_cnt_in;
         r_exit   <= w_cnt_out;
         r_err    <= w_err_seq | w_sat_err;
      end
   end

   assign occupancy   = r_occ;
   assign person_in   = r_person;
   assign entry_pulse = r_entry;
   assign exit_pulse  = r_exit;
   assign err_pulse   = r_err;

endmodule

// File: tb/tb_person_presence_detector.sv
// Randomized scoreboard bench for person_presence_detector (timeout model follows PRESENCE_TIMEOUT_EN).
module tb_person_presence_detector;

   localparam int unsigned CNT_W   = 2;
   localparam int unsigned OCC_MAX = 3;
   localparam int unsigned TO_CYC  = 50;
`ifdef PRESENCE_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst_a_n = 1'b0;
   logic             beam_out_i = 1'b0;
   logic             beam_in_i = 1'b0;
   logic             clr = 1'b0;
   logic             person_in;
   logic [CNT_W-1:0] occupancy;
   logic             entry_pulse;
   logic             exit_pulse;
   logic             err_pulse;

   always #5 clk = ~clk;

   person_presence_detector #(
      .CLK_HZ      (1000),
      .DEBOUNCE_MS (3),
      .TIMEOUT_MS  (50),
      .CNT_W       (CNT_W)
   ) dut (
      .clk         (clk),
      .rst_a_n     (rst_a_n),
      .beam_out_i  (beam_out_i),
      .beam_in_i   (beam_in_i),
      .clr         (clr),
      .person_in   (person_in),
      .occupancy   (occupancy),
      .entry_pulse (entry_pulse),
      .exit_pulse  (exit_pulse),
      .err_pulse   (err_pulse)
   );

   typedef struct packed {
      logic             ent;
      logic             ext;
      logic             err;
      logic [CNT_W-1:0] occ;
   } ev_t;

   ev_t         q[$];
   ev_t         mon_e;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   // Reference: direction is fixed by which beam breaks first from rest;
   // a pass counts only if the last beam still broken before rest is the far one.
   int unsigned m_occ = 0;
   bit          m_o   = 1'b0;
   bit          m_i   = 1'b0;
   int          m_dir = 0;   // 0 rest, 1 inward, 2 outward, 3 aborted

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_move(input bit no, input bit ni, input bit clr_hit);
      ev_t e;
      bit  push;
      e    = '0;
      push = 1'b0;
      if (!m_o && !m_i) begin
         if (no && ni) begin
            m_dir = 3; e.err = 1'b1; push = 1'b1;
         end else if (no) begin
            m_dir = 1;
         end else if (ni) begin
            m_dir = 2;
         end
      end else if (!no && !ni) begin
         if ((m_dir == 1 && !m_o && m_i) || (m_dir == 2 && m_o && !m_i)) begin
            push = 1'b1;
            if (m_dir == 1) e.ent = 1'b1; else e.ext = 1'b1;
            if (clr_hit)                          m_occ = 0;
            else if (m_dir == 1 && m_occ == OCC_MAX) e.err = 1'b1;
            else if (m_dir == 2 && m_occ == 0)       e.err = 1'b1;
            else if (m_dir == 1)                     m_occ++;
            else                                     m_occ--;
         end
         m_dir = 0;
      end
      m_o   = no;
      m_i   = ni;
      e.occ = CNT_W'(m_occ);
      if (push) q.push_back(e);
   endtask

   task automatic step(input bit no, input bit ni, input int unsigned hold);
      ev_t e;
      model_move(no, ni, 1'b0);
      if (TO_EN && hold > TO_CYC && (m_dir == 1 || m_dir == 2)) begin
         e = '0; e.err = 1'b1; e.occ = CNT_W'(m_occ);
         q.push_back(e);
         m_dir = 3;
      end
      @(negedge clk);
      beam_out_i = no;
      beam_in_i  = ni;
      repeat (hold) @(negedge clk);
      chk("occ_step", 32'(occupancy), m_occ);
      chk("person_step", 32'(person_in), 32'(m_occ != 0));
   endtask

   // Final clearing of the inner beam with clr landing on the counting edge:
   // 2 sync + 3 debounce edges, then the FSM edge.
   task automatic entry_finish_with_clr();
      model_move(1'b0, 1'b0, 1'b1);
      @(negedge clk);
      beam_out_i = 1'b0;
      beam_in_i  = 1'b0;
      repeat (5) @(posedge clk);
      @(negedge clk) clr = 1'b1;
      @(negedge clk) clr = 1'b0;
      repeat (8) @(negedge clk);
      chk("occ_after_clr", 32'(occupancy), m_occ);
   endtask

   task automatic full_entry();
      step(1'b1, 1'b0, 10); step(1'b1, 1'b1, 10); step(1'b0, 1'b1, 10); step(1'b0, 1'b0, 10);
   endtask

   task automatic full_exit();
      step(1'b0, 1'b1, 10); step(1'b1, 1'b1, 10); step(1'b1, 1'b0, 10); step(1'b0, 1'b0, 10);
   endtask

   always @(negedge clk) begin
      if (rst_a_n && (entry_pulse || exit_pulse || err_pulse)) begin
         if (entry_pulse && exit_pulse) chk("entry_exit_exclusive", 1, 0);
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_pulse: got entry=%0b exit=%0b err=%0b expected none at %0t",
                     entry_pulse, exit_pulse, err_pulse, $time);
         end else begin
            mon_e = q.pop_front();
            chk("entry_pulse", 32'(entry_pulse), 32'(mon_e.ent));
            chk("exit_pulse", 32'(exit_pulse), 32'(mon_e.ext));
            chk("err_pulse", 32'(err_pulse), 32'(mon_e.err));
            chk("occ_at_pulse", 32'(occupancy), 32'(mon_e.occ));
            chk("person_at_pulse", 32'(person_in), 32'(mon_e.occ != 0));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      bit          no;
      bit          ni;
      int unsigned r;
      int unsigned hold;

      #1;
      chk("rst_occ", 32'(occupancy), 0);
      chk("rst_person", 32'(person_in), 0);
      chk("rst_pulses", 32'({entry_pulse, exit_pulse, err_pulse}), 0);
      repeat (3) @(negedge clk);
      rst_a_n = 1'b1;
      repeat (3) @(negedge clk);

      full_entry();
      full_exit();
      full_exit();

      for (int k = 0; k < 10; k++) begin
         @(negedge clk) beam_out_i = ~beam_out_i;
         @(negedge clk);
         chk("bounce_db_out", 32'(dut.u_db_out.level_o), 0);
      end
      repeat (10) @(negedge clk);
      chk("bounce_occ", 32'(occupancy), m_occ);

      step(1'b1, 1'b0, 10); step(1'b1, 1'b1, 10); step(1'b1, 1'b0, 10); step(1'b0, 1'b0, 10);

      for (int k = 0; k < 4; k++) full_entry();
      step(1'b1, 1'b0, 10); step(1'b1, 1'b1, 10); step(1'b0, 1'b1, 10);
      entry_finish_with_clr();

      full_entry();
      step(1'b1, 1'b0, 60);
      step(1'b0, 1'b0, 10);

      step(1'b1, 1'b0, 10);
      step(1'b1, 1'b1, 10);
      chk("queue_before_reset", 32'(q.size()), 0);
      @(negedge clk) rst_a_n = 1'b0;
      #1;
      chk("midseq_rst_occ", 32'(occupancy), 0);
      chk("midseq_rst_person", 32'(person_in), 0);
      chk("midseq_rst_pulses", 32'({entry_pulse, exit_pulse, err_pulse}), 0);
      m_occ = 0; m_dir = 0; m_o = 1'b0; m_i = 1'b0;
      beam_out_i = 1'b0;
      beam_in_i  = 1'b0;
      repeat (5) @(negedge clk);
      rst_a_n = 1'b1;
      repeat (10) @(negedge clk);

      for (int k = 0; k < 80; k++) begin
         no   = m_o;
         ni   = m_i;
         r    = $urandom_range(0, 7);
         hold = $urandom_range(8, 20);
         if ((m_o == m_i) && r == 0) begin
            no = !m_o; ni = !m_i;
         end else if (r < 4) begin
            no = !m_o;
         end else begin
            ni = !m_i;
         end
         if ((no || ni) && $urandom_range(0, 11) == 0) hold = 65;
         step(no, ni, hold);
      end
      if (m_o || m_i) step(1'b0, 1'b0, 12);

      repeat (10) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
